// File: rtl/fc_act_collector.sv
// Collects one frame of signed FC-layer sums, applies ReLU + rounded shift
// requantisation, and replays the activations as an unsigned valid/ready stream.
module fc_act_collector #(
    parameter int N_OUT = 256,
    parameter int IN_W  = 16,
    parameter int OUT_W = 10,
    parameter int SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             frame_done,
    output logic             gap_err
);

    localparam int IDX_W = $clog2(N_OUT);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N_OUT - 1);
    localparam logic signed [IN_W:0]   RND      = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0]   MAX_EXT  = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic [OUT_W-1:0]       MAX_ACT  = OUT_W'(2 ** (OUT_W - 1) - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Handshake: a word moves on every rising edge where out_valid && out_ready;
    // out_data/out_last hold while out_valid && !out_ready. The input side has
    // no ready: every in_valid cycle outside DRAIN is a sample.
    state_t             state;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [OUT_W-1:0]   act_mem [N_OUT];

    logic signed [IN_W:0] sum_ext;
    logic signed [IN_W:0] rounded;
    logic [OUT_W-1:0]     act;
    logic                 accept;

    // One guard bit so the rounding add cannot overflow at the most positive sum.
    always_comb begin
        sum_ext = {in_sum[IN_W-1], in_sum};
        rounded = (sum_ext + RND) >>> SHIFT;
        act     = '0;
        if (!sum_ext[IN_W]) begin
            if (rounded > MAX_EXT) act = MAX_ACT;
            else                   act = rounded[OUT_W-1:0];
        end
    end

    assign accept = in_valid && (state != DRAIN);

    always_ff @(posedge clk) begin
        if (accept) act_mem[wr_idx] <= act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_idx     <= '0;
            rd_idx     <= '0;
            frame_done <= 1'b0;
            gap_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wr_idx <= IDX_W'(1);
                        state  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        if (wr_idx == LAST_IDX) begin
                            wr_idx <= '0;
                            state  <= DRAIN;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end else begin
                        gap_err <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx     <= '0;
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == DRAIN);
    assign out_last  = out_valid && (rd_idx == LAST_IDX);
    assign out_data  = out_valid ? act_mem[rd_idx] : '0;

endmodule

// File: tb/tb_fc_act_collector.sv
// Randomised bench for fc_act_collector: drives frames of sums and compares the
// drained stream with a reference built directly from the activation rules.
module tb_fc_act_collector;

    localparam int N_OUT = 256;
    localparam int IN_W  = 16;
    localparam int OUT_W = 10;
    localparam int SHIFT = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [IN_W-1:0]  in_sum;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             frame_done;
    logic             gap_err;

    fc_act_collector #(.N_OUT(N_OUT), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sum     (in_sum),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .gap_err    (gap_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int               n_cmp = 0;
    int               n_err = 0;
    logic [OUT_W-1:0] exp_q[$];
    int               frame_sums [1024];
    int               ready_pct = 100;
    bit               mon_en = 0;
    int               mon_xfer = 0;
    bit               exp_done = 0;
    bit               stall_prev = 0;
    logic [OUT_W-1:0] held_data = '0;
    logic             held_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference activation: ReLU, round half up by 2^SHIFT, clamp to the positive half-range.
    function automatic int act_ref(input int s);
        int r;
        if (s < 0) return 0;
        r = (s + 2 ** (SHIFT - 1)) / (2 ** SHIFT);
        if (r > 2 ** (OUT_W - 1) - 1) r = 2 ** (OUT_W - 1) - 1;
        return r;
    endfunction

    task automatic model_push(input int first, input int count);
        for (int i = first; i < first + count; i++) exp_q.push_back(OUT_W'(act_ref(frame_sums[i])));
    endtask

    // ---------------- drivers ----------------
    task automatic drive_samples(input int count, input int gap_after, input int gap_len);
        for (int i = 0; i < count; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_sum   = IN_W'(frame_sums[i]);
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    in_sum   = IN_W'($urandom);
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sum   = '0;
    endtask

    task automatic fill_random(input int first, input int count);
        for (int i = first; i < first + count; i++) frame_sums[i] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic wait_empty(input string tag);
        int budget = 4000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        check({tag, "_idx"}, 32'(mon_xfer), 32'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stall_prev && out_valid) begin
                    check("hold_data", 32'(out_data), 32'(held_data));
                    check("hold_last", 32'(out_last), 32'(held_last));
                end
                check("frame_done", 32'(frame_done), 32'(exp_done));
                exp_done = 0;
                if (out_valid && out_ready) begin
                    check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    check("out_last", 32'(out_last), 32'(mon_xfer == N_OUT - 1));
                    if (mon_xfer == N_OUT - 1) begin
                        mon_xfer = 0;
                        exp_done = 1;
                    end else begin
                        mon_xfer++;
                    end
                end
                stall_prev = out_valid && !out_ready;
                held_data  = out_data;
                held_last  = out_last;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int budget;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sum   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_gap_err", 32'(gap_err), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;

        // 1: ramp, each sum maps to its index
        for (int k = 0; k < N_OUT; k++) frame_sums[k] = 16 * k;
        check("ref_ramp_top", 32'(act_ref(frame_sums[255])), 32'd255);
        ready_pct = 100;
        model_push(0, N_OUT);
        drive_samples(N_OUT, -1, 0);
        wait_empty("ramp_drain");

        // 2: quantisation boundaries
        for (int k = 0; k < N_OUT; k++) frame_sums[k] = 0;
        frame_sums[0] = -5;   frame_sums[1] = 7;    frame_sums[2] = 8;
        frame_sums[3] = 32767; frame_sums[4] = 8184; frame_sums[5] = 8175;
        frame_sums[6] = -32768;
        model_push(0, N_OUT);
        drive_samples(N_OUT, -1, 0);
        wait_empty("quant_drain");

        // 3: backpressure
        fill_random(0, N_OUT);
        ready_pct = 30;
        model_push(0, N_OUT);
        drive_samples(N_OUT, -1, 0);
        wait_empty("bp_drain");
        check("gap_err_clean", 32'(gap_err), 32'd0);

        // 4: gap of 5 cycles after sample 100
        fill_random(0, N_OUT);
        ready_pct = 70;
        model_push(0, N_OUT);
        drive_samples(N_OUT, 100, 5);
        wait_empty("gap_drain");
        check("gap_err_set", 32'(gap_err), 32'd1);

        // 5: producer free-runs through DRAIN; next frame starts right after the last transfer
        fill_random(0, 3 * N_OUT);
        ready_pct = 100;
        @(posedge clk); #1;
        model_push(0, N_OUT);
        model_push(2 * N_OUT, N_OUT);
        drive_samples(3 * N_OUT, -1, 0);
        wait_empty("freerun_drain");
        check("gap_err_sticky", 32'(gap_err), 32'd1);

        // 6: reset in the middle of DRAIN
        fill_random(0, N_OUT);
        model_push(0, N_OUT);
        drive_samples(N_OUT, -1, 0);
        budget = 2000;
        while (mon_xfer < 40 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("rst_wait_idx", 32'(mon_xfer), 32'd40);
        #1;
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        check("midrst_gap_err", 32'(gap_err), 32'd0);
        exp_q.delete();
        mon_xfer   = 0;
        exp_done   = 0;
        stall_prev = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        fill_random(0, N_OUT);
        ready_pct = 50;
        model_push(0, N_OUT);
        drive_samples(N_OUT, -1, 0);
        wait_empty("post_rst_drain");
        check("post_rst_gap_err", 32'(gap_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
